// File: rtl/pattern_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_scan_pkg
//  Purpose  : Shared state encoding and default parameter values for the
//             pattern scan controller and its bit-serial matcher.
//  Revision : 1.0  initial release
// ============================================================================
package pattern_scan_pkg;

   // Job sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

   localparam int DEF_W     = 8;
   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/pattern_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_scan_ctrl_if
//  Purpose  : Word-stream valid/ready channel from a producer (master) into
//             the pattern scan controller (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface pattern_scan_ctrl_if
   import pattern_scan_pkg::*;
#(
   parameter int W = DEF_W
);
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/pattern_matcher.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_matcher
//  Purpose  : Bit-serial Mealy matcher. Keeps the last PAT_W-1 bits and a
//             fill counter; flags a match when the incoming bit completes the
//             pattern. Optional non-overlap mode clears history after a hit.
//  Config   : PATTERN_SCAN_OVERLAP_SEL_EN adds the overlap select input;
//             without it detection is always overlapping.
//  Revision : 1.0  initial release
// ============================================================================
module pattern_matcher
   import pattern_scan_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
)(
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             serial_bit,
   input  wire logic             bit_valid,
   input  wire logic [PAT_W-1:0] pattern,
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
   input  wire logic             overlap,
`endif
   input  wire logic             clear,
   output logic                  match
);
   localparam int FILL_W = $clog2(PAT_W);

   logic [PAT_W-2:0]  hist;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  window;
   logic              full;
   logic              hit_clear;

   assign window = {hist, serial_bit};
   assign full   = (fill == FILL_W'(PAT_W - 1));
   assign match  = bit_valid & full & (window == pattern);

`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
   assign hit_clear = match & ~overlap;
`else
   assign hit_clear = 1'b0;
`endif

   // History shift register and saturating fill counter
   always_ff @(posedge clk) begin
      if (reset || clear || hit_clear) begin
         hist <= '0;
         fill <= '0;
      end else if (bit_valid) begin
         hist <= window[PAT_W-2:0];
         if (!full) fill <= fill + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_scan_ctrl
//  Purpose  : Accepts a job of cfg_words words over a valid/ready channel,
//             serialises each word MSB-first into a pattern matcher and
//             counts matches (saturating). Pulses done at job end.
//  Config   : PATTERN_SCAN_OVERLAP_SEL_EN exposes cfg_overlap; without it
//             detection is always overlapping.
//  Revision : 1.0  initial release
// ============================================================================
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W
)(
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic [PAT_W-1:0] cfg_pattern,
   input  wire logic [CNT_W-1:0] cfg_words,
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
   input  wire logic             cfg_overlap,
`endif
   input  wire logic             start,
   output logic                  busy,
   output logic                  done,
   pattern_scan_ctrl_if.slave    in_bus,
   output logic                  match,
   output logic [CNT_W-1:0]      match_cnt
);
   localparam int IDX_W = $clog2(W);

   scan_state_t      state, state_nxt;
   logic [PAT_W-1:0] pat_q;
   logic [CNT_W-1:0] remaining;
   logic [IDX_W-1:0] bit_idx;
   logic [W-1:0]     shreg;
   logic             start_acc;
   logic             last_bit;
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
   logic             overlap_q;
`endif

   assign start_acc = (state == ST_IDLE) & start;
   assign last_bit  = (bit_idx == '0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status outputs
   always_comb begin
      state_nxt       = state;
      busy            = 1'b0;
      done            = 1'b0;
      in_bus.in_ready = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = (cfg_words == '0) ? ST_DONE : ST_LOAD;
         ST_LOAD: begin
            busy            = 1'b1;
            in_bus.in_ready = 1'b1;
            if (in_bus.in_valid) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            busy = 1'b1;
            // remaining==1 means this was the job's final word
            if (last_bit) state_nxt = (remaining == CNT_W'(1)) ? ST_DONE : ST_LOAD;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Job config latch, word/bit counters, shift register, match counter
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q     <= '0;
         remaining <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         match_cnt <= '0;
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
         overlap_q <= 1'b0;
`endif
      end else begin
         if (start_acc) begin
            pat_q     <= cfg_pattern;
            remaining <= cfg_words;
            match_cnt <= '0;
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
            overlap_q <= cfg_overlap;
`endif
         end
         if (state == ST_LOAD && in_bus.in_valid) begin
            shreg   <= in_bus.in_data;
            bit_idx <= IDX_W'(W - 1);
         end
         if (state == ST_SHIFT) begin
            shreg   <= shreg << 1;
            bit_idx <= bit_idx - 1'b1;
            if (last_bit) remaining <= remaining - 1'b1;
         end
         // match only occurs in SHIFT, so this never collides with the clear above
         if (match && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
      end
   end

   pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
      .clk        (clk),
      .reset      (reset),
      .serial_bit (shreg[W-1]),
      .bit_valid  (state == ST_SHIFT),
      .pattern    (pat_q),
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
      .overlap    (overlap_q),
`endif
      .clear      (start_acc),
      .match      (match)
   );
endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pattern_scan_ctrl
//  Purpose  : Self-checking bench for pattern_scan_ctrl: expected per-bit
//             match values are queued when a word is handed over and popped
//             as the word is shifted; job timing and counters are checked.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pattern_scan_ctrl;
   localparam int W     = 8;
   localparam int PAT_W = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic [CNT_W-1:0] cfg_words = '0;
   logic             cfg_overlap = 1'b1;
   logic             start = 1'b0;
   logic             busy, done, match;
   logic [CNT_W-1:0] match_cnt;
   pattern_scan_ctrl_if #(.W(W)) bus ();

   pattern_scan_ctrl #(.W(W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_pattern (cfg_pattern),
      .cfg_words   (cfg_words),
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
      .cfg_overlap (cfg_overlap),
`endif
      .start       (start),
      .busy        (busy),
      .done        (done),
      .in_bus      (bus),
      .match       (match),
      .match_cnt   (match_cnt)
   );

   // saturation instance with a 2-bit counter
   logic       s_start = 1'b0;
   logic       s_busy, s_done, s_match;
   logic [1:0] s_match_cnt;
   pattern_scan_ctrl_if #(.W(W)) bus2 ();

   pattern_scan_ctrl #(.W(W), .PAT_W(PAT_W), .CNT_W(2)) dut_sat (
      .clk         (clk),
      .reset       (reset),
      .cfg_pattern (4'b1111),
      .cfg_words   (2'd1),
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
      .cfg_overlap (1'b1),
`endif
      .start       (s_start),
      .busy        (s_busy),
      .done        (s_done),
      .in_bus      (bus2),
      .match       (s_match),
      .match_cnt   (s_match_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic         exp_q[$];
   logic         seg[$];
   int           m_cnt;
   logic [W-1:0] words_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: bits seen since last clear; hit when the newest PAT_W equal the pattern
   task automatic model_bit(input logic b, input logic [PAT_W-1:0] pat, input logic ov,
                            output logic hit);
      seg.push_back(b);
      hit = 1'b0;
      if (seg.size() >= PAT_W) begin
         hit = 1'b1;
         for (int i = 0; i < PAT_W; i++)
            if (seg[seg.size() - PAT_W + i] !== pat[PAT_W-1-i]) hit = 1'b0;
      end
      if (hit) begin
         if (m_cnt < 255) m_cnt++;
         if (!ov) seg.delete();
      end
      if (seg.size() > 64) void'(seg.pop_front());
   endtask

   // runs one job on the main instance starting at a falling edge
   task automatic run_job(input string name, input logic [PAT_W-1:0] pat, input logic ov,
                          input int stall, input int abort_word, input int exp_cnt);
      int   n;
      int   k;
      int   want;
      logic hit;
      logic e;
      n = words_q.size();
      seg.delete();
      exp_q.delete();
      m_cnt = 0;
      cfg_pattern = pat;
      cfg_words   = CNT_W'(n);
      cfg_overlap = ov;
      start = 1'b1;
      k = cyc;
      @(negedge clk);
      start = 1'b0;
      if (n == 0) begin
         check_val({name, " done"}, 32'(done), 32'd1);
         check_val({name, " busy"}, 32'(busy), 32'd0);
         check_val({name, " in_ready"}, 32'(bus.in_ready), 32'd0);
         check_val({name, " done_cyc"}, 32'(cyc - k), 32'd1);
         @(negedge clk);
         check_val({name, " done_pulse"}, 32'(done), 32'd0);
         check_val({name, " cnt"}, 32'(match_cnt), 32'd0);
         return;
      end
      check_val({name, " load_busy"}, 32'(busy), 32'd1);
      check_val({name, " load_ready"}, 32'(bus.in_ready), 32'd1);
      for (int w = 0; w < n; w++) begin
         for (int s = 0; s < ((w == 0) ? stall : 0); s++) begin
            check_val({name, " stall_ready"}, 32'(bus.in_ready), 32'd1);
            check_val({name, " stall_match"}, 32'(match), 32'd0);
            // a start and config changes mid-job must be ignored
            start = 1'b1;
            cfg_pattern = ~pat;
            cfg_words = '0;
            @(negedge clk);
         end
         start = 1'b0;
         cfg_pattern = pat;
         cfg_words = CNT_W'(n);
         bus.in_valid = 1'b1;
         bus.in_data  = words_q[w];
         for (int b = W - 1; b >= 0; b--) begin
            model_bit(words_q[w][b], pat, ov, hit);
            exp_q.push_back(hit);
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         check_val({name, " shift_ready"}, 32'(bus.in_ready), 32'd0);
         for (int b = W - 1; b >= 0; b--) begin
            e = exp_q.pop_front();
            check_val($sformatf("%s match w%0d b%0d", name, w, b), 32'(match), 32'(e));
            if (w == abort_word && b == 3) begin
               reset = 1'b1;
               @(negedge clk);
               reset = 1'b0;
               check_val({name, " rst_busy"}, 32'(busy), 32'd0);
               check_val({name, " rst_done"}, 32'(done), 32'd0);
               check_val({name, " rst_ready"}, 32'(bus.in_ready), 32'd0);
               check_val({name, " rst_match"}, 32'(match), 32'd0);
               check_val({name, " rst_cnt"}, 32'(match_cnt), 32'd0);
               exp_q.delete();
               return;
            end
            @(negedge clk);
         end
      end
      want = (exp_cnt < 0) ? m_cnt : exp_cnt;
      check_val({name, " done"}, 32'(done), 32'd1);
      check_val({name, " done_busy"}, 32'(busy), 32'd0);
      check_val({name, " done_cyc"}, 32'(cyc - k), 32'(1 + n * (W + 1) + stall));
      check_val({name, " cnt"}, 32'(match_cnt), 32'(want));
      @(negedge clk);
      check_val({name, " done_pulse"}, 32'(done), 32'd0);
      check_val({name, " cnt_hold"}, 32'(match_cnt), 32'(want));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int pulses;
      logic ov;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus2.in_valid = 1'b1;
      bus2.in_data  = 8'hFF;
      repeat (3) @(negedge clk);
      check_val("reset busy", 32'(busy), 32'd0);
      check_val("reset done", 32'(done), 32'd0);
      check_val("reset in_ready", 32'(bus.in_ready), 32'd0);
      check_val("reset match", 32'(match), 32'd0);
      check_val("reset match_cnt", 32'(match_cnt), 32'd0);
      check_val("reset sat_cnt", 32'(s_match_cnt), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      words_q.delete(); words_q.push_back(8'hDB);
      run_job("t1", 4'b1101, 1'b1, 0, -1, 2);
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
      run_job("t2", 4'b1101, 1'b0, 0, -1, 1);
`endif
      words_q.delete(); words_q.push_back(8'h01); words_q.push_back(8'hA0);
      run_job("t3", 4'b1101, 1'b1, 0, -1, 1);
      words_q.delete();
      run_job("t4a", 4'b1101, 1'b1, 0, -1, 0);
      words_q.delete(); words_q.push_back(8'hDB);
      run_job("t4b", 4'b1101, 1'b1, 5, -1, 2);
      words_q.delete();
      for (int i = 0; i < 4; i++) words_q.push_back(8'hDB);
      run_job("t6a", 4'b1101, 1'b1, 0, 1, 0);
      words_q.delete(); words_q.push_back(8'h0D);
      run_job("t6b", 4'b1101, 1'b1, 0, -1, 1);

      for (int r = 0; r < 4; r++) begin
         words_q.delete();
         for (int i = 0; i < int'($urandom_range(1, 3)); i++) words_q.push_back(W'($urandom));
`ifdef PATTERN_SCAN_OVERLAP_SEL_EN
         ov = 1'($urandom);
`else
         ov = 1'b1;
`endif
         run_job($sformatf("rnd%0d", r), PAT_W'($urandom), ov, 0, -1, -1);
      end

      // saturation: 0xFF against 1111 gives five overlapping hits into a 2-bit counter
      s_start = 1'b1;
      k = cyc;
      pulses = 0;
      @(negedge clk);
      s_start = 1'b0;
      check_val("t5 load_ready", 32'(bus2.in_ready), 32'd1);
      for (int i = 1; i < 10; i++) begin
         if (s_match) pulses++;
         @(negedge clk);
      end
      check_val("t5 done", 32'(s_done), 32'd1);
      check_val("t5 done_cyc", 32'(cyc - k), 32'd10);
      check_val("t5 pulses", 32'(pulses), 32'd5);
      check_val("t5 sat_cnt", 32'(s_match_cnt), 32'd3);
      check_val("t5 busy", 32'(s_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
